xc_malu_seq: RTL and testbench

- Sequencer and state-holding stage directly upstream of the multi-cycle multiply/divide/remainder datapath.
- Accepts one operation from the core over a valid/ready handshake and latches the operands and op flags.
- Owns the count, acc, arg_0 and arg_1 iteration registers and drives them into the combinational datapath.
- Each cycle it writes back the datapath's next-state values until the datapath signals ready, then holds the 32-bit result until the core accepts it.

---
 rtl/xc_malu_seq.sv | 201 ++++++++++++++++++++
 tb/tb_xc_malu_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xc_malu_seq.sv
// xc_malu_seq: sequencer and state-holding stage in front of the multi-cycle
// multiply/divide/remainder datapath.
//
// Takes one operation over a valid/ready handshake and latches its operands and
// op flags. It then drives its iteration registers (count, acc, arg_0, arg_1)
// into the combinational datapath. Each cycle it writes back the datapath's
// next-state values until the datapath raises dp_ready. The selected 32-bit
// result is held until the core accepts it.
//
// Ports
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   flush                    abandon any in-flight operation (synchronous)
//   req_valid/req_ready      request handshake
//   req_rs1/2/3, req_op      operands and one-hot op
//   req_pw, req_hi           packed width and result-half select
//   dp_valid                 state and operands to the datapath are valid
//   dp_rs1/2/3, dp_op        latched request fields
//   dp_pw                    latched packed width
//   count, acc, arg_0/1      iteration registers
//   dp_n_acc, dp_n_arg_0/1   next iteration values from the datapath
//   dp_result, dp_ready      datapath result and its valid
//   rsp_valid/rsp_ready      response handshake
//   rsp_result, rsp_err      selected result word; abort flag set at MAX_CNT
module xc_malu_seq #(
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned MAX_CNT = 63
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [31:0]      req_rs3,
    input  logic [9:0]       req_op,
    input  logic [4:0]       req_pw,
    input  logic             req_hi,
    output logic             dp_valid,
    output logic [31:0]      dp_rs1,
    output logic [31:0]      dp_rs2,
    output logic [31:0]      dp_rs3,
    output logic [9:0]       dp_op,
    output logic [4:0]       dp_pw,
    output logic [CNT_W-1:0] count,
    output logic [63:0]      acc,
    output logic [31:0]      arg_0,
    output logic [31:0]      arg_1,
    input  logic [63:0]      dp_n_acc,
    input  logic [31:0]      dp_n_arg_0,
    input  logic [31:0]      dp_n_arg_1,
    input  logic [63:0]      dp_result,
    input  logic             dp_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      rs1_q, rs1_d;
    logic [31:0]      rs2_q, rs2_d;
    logic [31:0]      rs3_q, rs3_d;
    logic [9:0]       op_q, op_d;
    logic [4:0]       pw_q, pw_d;
    logic             hi_q, hi_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [63:0]      acc_q, acc_d;
    logic [31:0]      arg_0_q, arg_0_d;
    logic [31:0]      arg_1_q, arg_1_d;
    logic [31:0]      result_q, result_d;
    logic             err_q, err_d;

    always_comb begin
        state_d  = state_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rs3_d    = rs3_q;
        op_d     = op_q;
        pw_d     = pw_q;
        hi_d     = hi_q;
        count_d  = count_q;
        acc_d    = acc_q;
        arg_0_d  = arg_0_q;
        arg_1_d  = arg_1_q;
        result_d = result_q;
        err_d    = err_q;

        req_ready = (state_q == StIdle) && !flush;

        case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    rs1_d    = req_rs1;
                    rs2_d    = req_rs2;
                    rs3_d    = req_rs3;
                    op_d     = req_op;
                    pw_d     = req_pw;
                    hi_d     = req_hi;
                    count_d  = '0;
                    acc_d    = '0;
                    arg_0_d  = '0;
                    arg_1_d  = '0;
                    result_d = '0;
                    err_d    = 1'b0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (dp_ready) begin
                    // Iteration registers are left as they are on completion.
                    result_d = hi_q ? dp_result[63:32] : dp_result[31:0];
                    err_d    = 1'b0;
                    state_d  = StDone;
                end else if (count_q == CNT_W'(MAX_CNT)) begin
                    // Abort before the counter can wrap.
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = StDone;
                end else begin
                    acc_d   = dp_n_acc;
                    arg_0_d = dp_n_arg_0;
                    arg_1_d = dp_n_arg_1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Flush overrides everything, including a response handshake in DONE.
        if (flush) begin
            state_d  = StIdle;
            count_d  = '0;
            acc_d    = '0;
            arg_0_d  = '0;
            arg_1_d  = '0;
            result_d = '0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rs3_q    <= '0;
            op_q     <= '0;
            pw_q     <= '0;
            hi_q     <= 1'b0;
            count_q  <= '0;
            acc_q    <= '0;
            arg_0_q  <= '0;
            arg_1_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rs3_q    <= rs3_d;
            op_q     <= op_d;
            pw_q     <= pw_d;
            hi_q     <= hi_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            arg_0_q  <= arg_0_d;
            arg_1_q  <= arg_1_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign dp_valid   = (state_q == StRun);
    assign rsp_valid  = (state_q == StDone);
    assign dp_rs1     = rs1_q;
    assign dp_rs2     = rs2_q;
    assign dp_rs3     = rs3_q;
    assign dp_op      = op_q;
    assign dp_pw      = pw_q;
    assign count      = count_q;
    assign acc        = acc_q;
    assign arg_0      = arg_0_q;
    assign arg_1      = arg_1_q;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_xc_malu_seq.sv
// Testbench for xc_malu_seq.
//
// A stub datapath adds 5 to acc each cycle. It raises dp_ready at count == 3
// (mode 0) or never (mode 1). Its dp_result is {32'hA, acc[31:0]}.
// Expected responses go into a queue when a request is issued. A monitor pops
// and compares them on every response handshake.
module tb_xc_malu_seq;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [31:0] req_rs3;
    logic [9:0]  req_op;
    logic [4:0]  req_pw;
    logic        req_hi;
    logic        dp_valid;
    logic [31:0] dp_rs1;
    logic [31:0] dp_rs2;
    logic [31:0] dp_rs3;
    logic [9:0]  dp_op;
    logic [4:0]  dp_pw;
    logic [5:0]  count;
    logic [63:0] acc;
    logic [31:0] arg_0;
    logic [31:0] arg_1;
    logic [63:0] dp_n_acc;
    logic [31:0] dp_n_arg_0;
    logic [31:0] dp_n_arg_1;
    logic [63:0] dp_result;
    logic        dp_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;

    int mode;
    int n_checks;
    int n_fail;
    logic [32:0] exp_q[$];  // {err, result}

    xc_malu_seq #(
        .CNT_W  (6),
        .MAX_CNT(63)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_rs3   (req_rs3),
        .req_op    (req_op),
        .req_pw    (req_pw),
        .req_hi    (req_hi),
        .dp_valid  (dp_valid),
        .dp_rs1    (dp_rs1),
        .dp_rs2    (dp_rs2),
        .dp_rs3    (dp_rs3),
        .dp_op     (dp_op),
        .dp_pw     (dp_pw),
        .count     (count),
        .acc       (acc),
        .arg_0     (arg_0),
        .arg_1     (arg_1),
        .dp_n_acc  (dp_n_acc),
        .dp_n_arg_0(dp_n_arg_0),
        .dp_n_arg_1(dp_n_arg_1),
        .dp_result (dp_result),
        .dp_ready  (dp_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_err   (rsp_err)
    );

    // Stub datapath
    assign dp_ready   = (mode == 0) && dp_valid && (count == 6'd3);
    assign dp_n_acc   = acc + 64'd5;
    assign dp_n_arg_0 = arg_0 + 32'd1;
    assign dp_n_arg_1 = arg_1 ^ dp_rs2;
    assign dp_result  = {32'h0000_000A, acc[31:0]};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: compare every accepted response against the scoreboard.
    always @(negedge clock) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got result %0h err %0b expected none",
                         rsp_result, rsp_err);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("rsp_result", {32'd0, rsp_result}, {32'd0, e[31:0]});
                check("rsp_err", {63'd0, rsp_err}, {63'd0, e[32]});
            end
        end
    end

    // Present a request and wait (bounded) until the accepting edge has passed.
    task automatic issue(input logic [31:0] rs1, input logic [9:0] op, input logic hi,
                         input logic [32:0] expect_rsp);
        int   n;
        logic taken;
        req_rs1   = rs1;
        req_rs2   = 32'h1234_5678;
        req_rs3   = 32'hCAFE_0003;
        req_op    = op;
        req_pw    = 5'b10000;
        req_hi    = hi;
        req_valid = 1'b1;
        n     = 0;
        taken = 1'b0;
        while (!taken && n < 50) begin
            #1;
            if (req_ready) taken = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        if (!taken) check("req_accept_timeout", 64'd0, 64'd1);
        exp_q.push_back(expect_rsp);
        tick();
        req_valid = 1'b0;
        req_rs1   = 32'hDEAD_BEEF;  // changes after accept must be ignored
        req_op    = 10'h3FF;
        req_hi    = ~hi;
    endtask

    // Count rising edges from the accepting edge (inclusive) to rsp_valid.
    task automatic wait_rsp(output int edges);
        edges = 1;
        while (!rsp_valid && edges < 200) begin
            tick();
            edges++;
        end
        if (!rsp_valid) check("rsp_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int   edges;
        int   max_cnt;
        int   prev_cnt;
        logic wrapped;
        logic seen;

        n_checks  = 0;
        n_fail    = 0;
        mode      = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_rs3   = '0;
        req_op    = '0;
        req_pw    = '0;
        req_hi    = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        // Reset state
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_dp_valid", {63'd0, dp_valid}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_count", {58'd0, count}, 64'd0);
        check("rst_acc", acc, 64'd0);
        check("rst_rsp", {31'd0, rsp_err, rsp_result}, 64'd0);
        check("rst_dp_rs1", {32'd0, dp_rs1}, 64'd0);
        reset = 1'b0;
        tick();

        // mul, low half: acc = 3 * 5 = 15 when dp_ready fires at count 3
        issue(32'h0000_0011, 10'b0000010000, 1'b0, {1'b0, 32'd15});
        check("run_dp_valid", {63'd0, dp_valid}, 64'd1);
        check("run_dp_rs1_held", {32'd0, dp_rs1}, 64'h11);
        check("run_dp_op_held", {54'd0, dp_op}, 64'h010);
        wait_rsp(edges);
        check("latency_mul", edges, 64'd5);
        check("done_acc_held", acc, 64'd15);
        tick();

        // High half, with an illegal (two-hot) op that must still be sequenced
        issue(32'h0000_0022, 10'b0000000011, 1'b1, {1'b0, 32'h0000_000A});
        check("illegal_op_held", {54'd0, dp_op}, 64'h003);
        wait_rsp(edges);
        tick();

        // dp_ready never rises: abort at MAX_CNT without wrapping
        mode = 1;
        issue(32'h0000_0033, 10'b0000000001, 1'b0, {1'b1, 32'd0});
        max_cnt  = 0;
        prev_cnt = 0;
        wrapped  = 1'b0;
        edges    = 0;
        while (!rsp_valid && edges < 200) begin
            if (dp_valid) begin
                if (int'(count) < prev_cnt) wrapped = 1'b1;
                prev_cnt = int'(count);
                if (int'(count) > max_cnt) max_cnt = int'(count);
            end
            tick();
            edges++;
        end
        check("abort_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("abort_max_count", max_cnt, 64'd63);
        check("abort_no_wrap", {63'd0, wrapped}, 64'd0);
        tick();
        mode = 0;

        // Flush while running at count == 2
        issue(32'h0000_0044, 10'b0000010000, 1'b0, 33'd0);
        void'(exp_q.pop_back());  // flushed requests produce no response
        edges = 0;
        while (count != 6'd2 && edges < 20) begin
            tick();
            edges++;
        end
        check("flush_reach_cnt2", {58'd0, count}, 64'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("flush_idle", {63'd0, dp_valid}, 64'd0);
        check("flush_count", {58'd0, count}, 64'd0);
        check("flush_acc", acc, 64'd0);
        check("flush_req_ready", {63'd0, req_ready}, 64'd1);
        seen = 1'b0;
        repeat (10) begin
            if (rsp_valid) seen = 1'b1;
            tick();
        end
        check("flush_no_rsp", {63'd0, seen}, 64'd0);

        // Flush together with req_valid in IDLE: not taken; taken next cycle
        req_rs1   = 32'h55;
        req_op    = 10'b0000100000;
        req_hi    = 1'b0;
        flush     = 1'b1;
        req_valid = 1'b1;
        #1;
        check("flush_req_ready_low", {63'd0, req_ready}, 64'd0);
        tick();
        check("flush_req_stay_idle", {62'd0, dp_valid, rsp_valid}, 64'd0);
        flush = 1'b0;
        #1;
        check("post_flush_req_ready", {63'd0, req_ready}, 64'd1);
        exp_q.push_back({1'b0, 32'd15});
        tick();
        req_valid = 1'b0;
        check("post_flush_accept", {63'd0, dp_valid}, 64'd1);
        check("post_flush_rs1", {32'd0, dp_rs1}, 64'h55);
        wait_rsp(edges);
        tick();

        // Response backpressure for 10 cycles, then back-to-back request
        rsp_ready = 1'b0;
        issue(32'h0000_0066, 10'b0000100000, 1'b0, {1'b0, 32'd15});
        wait_rsp(edges);
        repeat (10) begin
            check("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            check("hold_rsp_result", {32'd0, rsp_result}, 64'd15);
            check("hold_req_ready", {63'd0, req_ready}, 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        req_rs1   = 32'h77;
        req_op    = 10'b0000100000;
        req_hi    = 1'b1;
        req_valid = 1'b1;
        #1;
        check("b2b_req_ready_done", {63'd0, req_ready}, 64'd0);
        tick();
        check("b2b_idle", {63'd0, rsp_valid}, 64'd0);
        check("b2b_req_ready_idle", {63'd0, req_ready}, 64'd1);
        exp_q.push_back({1'b0, 32'h0000_000A});
        tick();
        req_valid = 1'b0;
        check("b2b_accept", {63'd0, dp_valid}, 64'd1);
        check("b2b_rs1", {32'd0, dp_rs1}, 64'h77);
        wait_rsp(edges);
        tick();

        // Drain the scoreboard
        edges = 0;
        while (exp_q.size() != 0 && edges < 50) begin
            tick();
            edges++;
        end
        check("scoreboard_empty", exp_q.size(), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
